// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and funct3 constants for the MEM-stage store path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  web;
    } st_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/store_fmt.sv
// ============================================================================
// Module      : store_fmt
// Description : Combinational store legality check and byte-lane formatting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_fmt
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_legal,
    output st_entry_t   o_entry
);

    always_comb begin
        o_legal       = 1'b0;
        o_entry.waddr = i_addr[31:2];
        o_entry.wdata = i_data;
        o_entry.web   = 4'b1111;
        case (i_funct3)
            F3_SB: begin
                o_legal       = 1'b1;
                o_entry.wdata = {4{i_data[7:0]}};
                o_entry.web   = ~(4'b0001 << i_addr[1:0]);
            end
            F3_SH: begin
                o_legal       = ~i_addr[0];
                o_entry.wdata = {2{i_data[15:0]}};
                o_entry.web   = i_addr[1] ? 4'b0011 : 4'b1100;
            end
            F3_SW: begin
                o_legal       = (i_addr[1:0] == 2'b00);
                o_entry.web   = 4'b0000;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_store_buffer.sv
// ============================================================================
// Module      : mem_store_buffer
// Description : Store FIFO with lane formatting, req/ack drain FSM and load
//               conflict detection for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        st_err,
    input  logic        ld_check_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_web,
    input  logic        dm_ack,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    st_entry_t    r_fifo [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    drain_state_t r_state;
    logic         r_err;

    logic         w_legal;
    st_entry_t    w_entry;
    st_entry_t    w_head;
    logic [PW-1:0] w_count;
    logic         w_full;
    logic         w_empty;
    logic         w_take;
    logic         w_push;
    logic         w_pop;
    logic         w_hit;
    logic [1:0]   w_unused_ld;

    store_fmt u_fmt (
        .i_funct3 (st_funct3),
        .i_addr   (st_addr),
        .i_data   (st_data),
        .o_legal  (w_legal),
        .o_entry  (w_entry)
    );

    assign w_count = r_wptr - r_rptr;
    assign w_full  = ((r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}});
    assign w_empty = (r_wptr == r_rptr);
    // Illegal requests still consume the handshake so st_err can be reported.
    assign w_take  = st_valid && !w_full;
    assign w_push  = w_take && w_legal;
    assign w_pop   = (r_state == REQ) && dm_ack;
    assign w_head  = r_fifo[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_take && !w_legal;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case (r_state)
                IDLE: if (!w_empty) r_state <= REQ;
                REQ:  if (w_pop && (w_count == PW'(1)) && !w_push) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Only slots between the read and write pointers hold live stores.
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW'(k) < w_count) &&
                (r_fifo[r_rptr[AW-1:0] + AW'(k)].waddr == ld_addr[31:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign w_unused_ld = ld_addr[1:0];

    assign st_ready    = !w_full;
    assign empty       = w_empty;
    assign st_err      = r_err;
    assign ld_conflict = ld_check_valid && w_hit;
    assign dm_req      = (r_state == REQ);
    assign dm_addr     = dm_req ? {w_head.waddr, 2'b00} : 32'h0;
    assign dm_wdata    = dm_req ? w_head.wdata : 32'h0;
    assign dm_web      = dm_req ? w_head.web : 4'b1111;

endmodule

`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
// ============================================================================
// Module      : tb_mem_store_buffer
// Description : Randomized scoreboard bench for mem_store_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_store_buffer;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_err;
    logic        ld_check_valid;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_web;
    logic        dm_ack;
    logic        empty;

    mem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_funct3      (st_funct3),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .st_err         (st_err),
        .ld_check_valid (ld_check_valid),
        .ld_addr        (ld_addr),
        .ld_conflict    (ld_conflict),
        .dm_req         (dm_req),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_web         (dm_web),
        .dm_ack         (dm_ack),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  web;
    } txn_t;

    txn_t        exp_q[$];
    logic [29:0] pend_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [2:0] f, input logic [31:0] a);
        return (f == 3'd0) || (f == 3'd1 && a[0] == 1'b0) || (f == 3'd2 && a[1:0] == 2'd0);
    endfunction

    // Reference formatting: replicate the low bytes, clear the enables of the touched lanes.
    function automatic txn_t fmt(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.addr = {a[31:2], 2'b00};
        t.web  = 4'b1111;
        if (f == 3'd0) begin
            t.wdata = {24'h0, d[7:0]} * 32'h01010101;
            t.web[a[1:0]] = 1'b0;
        end else if (f == 3'd1) begin
            t.wdata = {16'h0, d[15:0]} * 32'h00010001;
            t.web[a[1:0]] = 1'b0;
            t.web[a[1:0] + 2'd1] = 1'b0;
        end else begin
            t.wdata = d;
            t.web   = 4'b0000;
        end
        return t;
    endfunction

    // Occupancy model: a request is visible once an entry has been held for a full cycle.
    int   occ      = 0;
    int   occ_prev = 0;
    logic err_exp  = 1'b0;

    always @(negedge clk) begin : model
        logic exp_req;
        logic hit;
        logic take;
        logic pop;
        if (rst) begin
            occ = 0;
            occ_prev = 0;
            err_exp = 1'b0;
            pend_q.delete();
            exp_q.delete();
        end
        exp_req = (occ > 0) && (occ_prev > 0);
        hit = 1'b0;
        foreach (pend_q[i]) if (pend_q[i] == ld_addr[31:2]) hit = 1'b1;
        check("st_ready", 32'(st_ready), 32'(occ < DEPTH));
        check("empty", 32'(empty), 32'(occ == 0));
        check("dm_req", 32'(dm_req), 32'(exp_req));
        check("st_err", 32'(st_err), 32'(err_exp));
        check("ld_conflict", 32'(ld_conflict), 32'(ld_check_valid && hit));
        if (!exp_req) begin
            check("idle_addr", dm_addr, 32'h0);
            check("idle_wdata", dm_wdata, 32'h0);
            check("idle_web", 32'(dm_web), 32'hF);
        end
        if (!rst) begin
            take    = st_valid && (occ < DEPTH);
            pop     = exp_req && dm_ack;
            err_exp = take && !is_legal(st_funct3, st_addr);
            if (take && is_legal(st_funct3, st_addr)) begin
                exp_q.push_back(fmt(st_funct3, st_addr, st_data));
                pend_q.push_back(st_addr[31:2]);
            end
            if (pop) void'(pend_q.pop_front());
            occ_prev = occ;
            occ = pend_q.size();
        end
    end

    always @(negedge clk) begin : monitor
        txn_t t;
        if (!rst && dm_req && dm_ack) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dm_txn: got write to %0h, expected none", dm_addr);
            end else begin
                t = exp_q.pop_front();
                check("dm_addr", dm_addr, t.addr);
                check("dm_wdata", dm_wdata, t.wdata);
                check("dm_web", 32'(dm_web), 32'(t.web));
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic ack, input logic lv,
                         input logic [31:0] la);
        @(posedge clk);
        #1;
        st_valid = v; st_funct3 = f; st_addr = a; st_data = d;
        dm_ack = ack; ld_check_valid = lv; ld_addr = la;
    endtask

    initial begin
        int ack_pct;
        rst = 1'b1;
        st_valid = 1'b0; st_funct3 = 3'd0; st_addr = 32'h0; st_data = 32'h0;
        dm_ack = 1'b0; ld_check_valid = 1'b0; ld_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // SB lane formatting and first-request latency
        drive(1, 3'd0, 32'h1003, 32'h000000AB, 0, 0, 0);
        drive(0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        drive(0, 3'd0, 32'h0, 32'h0, 1, 0, 0);
        // SH, then misaligned SW dropped with error pulse
        drive(1, 3'd1, 32'h2002, 32'h00001234, 1, 0, 0);
        drive(0, 3'd0, 32'h0, 32'h0, 1, 0, 0);
        repeat (2) drive(0, 3'd0, 32'h0, 32'h0, 1, 0, 0);
        drive(1, 3'd2, 32'h2001, 32'hDEADBEEF, 1, 0, 0);
        repeat (2) drive(0, 3'd0, 32'h0, 32'h0, 1, 0, 0);

        // Fill with ack held low, third store stalls until one ack
        drive(1, 3'd2, 32'h100, 32'h11111111, 0, 0, 0);
        drive(1, 3'd2, 32'h104, 32'h22222222, 0, 0, 0);
        drive(1, 3'd2, 32'h108, 32'h33333333, 0, 0, 0);
        drive(1, 3'd2, 32'h108, 32'h33333333, 0, 0, 0);
        drive(1, 3'd2, 32'h108, 32'h33333333, 1, 0, 0);
        drive(0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        repeat (4) drive(0, 3'd0, 32'h0, 32'h0, 1, 0, 0);

        // Push and ack at the same edge with one entry pending
        drive(1, 3'd2, 32'h200, 32'hA0A0A0A0, 0, 0, 0);
        drive(0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        drive(1, 3'd2, 32'h204, 32'hB0B0B0B0, 1, 0, 0);
        repeat (3) drive(0, 3'd0, 32'h0, 32'h0, 1, 0, 0);

        // Load conflict against a pending word
        drive(1, 3'd2, 32'h3004, 32'h55AA55AA, 0, 0, 0);
        drive(0, 3'd0, 32'h0, 32'h0, 0, 1, 32'h3006);
        drive(0, 3'd0, 32'h0, 32'h0, 0, 1, 32'h3008);
        drive(0, 3'd0, 32'h0, 32'h0, 1, 1, 32'h3004);
        repeat (2) drive(0, 3'd0, 32'h0, 32'h0, 0, 1, 32'h3004);

        // Asynchronous reset while draining with two entries held
        drive(1, 3'd2, 32'h400, 32'h12121212, 0, 0, 0);
        drive(1, 3'd2, 32'h404, 32'h34343434, 0, 0, 0);
        repeat (2) drive(0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_dm_req", 32'(dm_req), 32'h0);
        check("rst_dm_web", 32'(dm_web), 32'hF);
        check("rst_empty", 32'(empty), 32'h1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 3'd0, 32'h5001, 32'h000000C3, 1, 0, 0);
        repeat (4) drive(0, 3'd0, 32'h0, 32'h0, 1, 0, 0);

        // Randomized traffic with varying memory back-pressure
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0:       ack_pct = 100;
                1:       ack_pct = 50;
                default: ack_pct = 10;
            endcase
            drive(($urandom % 10) < 6,
                  (($urandom % 8) < 6) ? 3'($urandom % 3) : 3'($urandom % 8),
                  32'h4000 + $urandom_range(0, 23),
                  $urandom,
                  ($urandom % 100) < ack_pct,
                  ($urandom % 2) == 0,
                  32'h4000 + $urandom_range(0, 23));
        end
        repeat (10) drive(0, 3'd0, 32'h0, 32'h0, 1, 0, 0);
        @(negedge clk);
        check("final_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
